nx_fifo_1r1w_hw_ctrl: RTL and testbench
=======================================

NX_FIFO_1R1W_HW_CTRL -- requirements
Module: nx_fifo_1r1w_hw_ctrl

Interface
REQ-001 Parameter N_DATA_BITS, default 32, data word width.
REQ-002 Parameter N_ENTRIES, default 16, RAM depth; a power of two, at least 2.
REQ-003 Parameter RD_LATENCY, default 2, cycles from mem_re to valid mem_dout; range 1..4.
REQ-004 Ports clk (input, 1) and rst_n (input, 1): one clock; reset is asynchronous and active-low.
REQ-005 in_vld input 1: push request; in_dat input N_DATA_BITS: push data; in_rdy output 1: push accept.
REQ-006 out_vld output 1: pop data valid; out_dat output N_DATA_BITS: pop data; out_rdy input 1: pop accept.
REQ-007 mem_cs, mem_we, mem_re outputs 1: RAM hw-port chip select, write enable and read enable.
REQ-008 mem_waddr, mem_raddr outputs log2(N_ENTRIES): RAM write and read addresses; mem_din output N_DATA_BITS: RAM write data.
REQ-009 mem_dout input N_DATA_BITS: RAM read data; mem_yield input 1: the indirect-access controller requests the RAM port.
REQ-010 count output log2(N_ENTRIES+RD_LATENCY+1)+1: total words held; empty output 1; full output 1.

Function
REQ-011 Push fires when in_vld and in_rdy are both 1: mem_cs=1, mem_we=1, mem_waddr=wptr, mem_din=in_dat; wptr increments modulo N_ENTRIES.
REQ-012 in_rdy = (ram_cnt < N_ENTRIES) and not mem_yield; in_rdy does not depend on in_vld.
REQ-013 Output buffer: RD_LATENCY+1 entry register FIFO; credit = buffer occupancy + reads in flight.
REQ-014 Read issues when ram_cnt > 0, credit < RD_LATENCY+1 and mem_yield=0: mem_cs=1, mem_re=1, mem_raddr=rptr; rptr increments modulo N_ENTRIES.
REQ-015 A read never targets the entry written in the same cycle; ram_cnt counts only writes committed at earlier clock edges.
REQ-016 In-flight valid shifts through an RD_LATENCY-stage pipe; at the final stage mem_dout is written into the output buffer.
REQ-017 out_vld = buffer not empty; out_dat = buffer head; the head is popped when out_vld and out_rdy are both 1.
REQ-018 Latency: a push accepted in cycle t into an empty block gives out_vld=1 in cycle t+RD_LATENCY+2.
REQ-019 Simultaneous push and read in one cycle are both allowed; ram_cnt is unchanged.
REQ-020 Simultaneous buffer fill and pop in one cycle are both allowed; buffer occupancy is unchanged.
REQ-021 mem_yield=1 means no push accept, no read issue and mem_cs=0 that cycle; in-flight reads and pops continue.
REQ-022 mem_cs=0 whenever there is neither a push nor a read; mem_we and mem_re are 0 when not active.
REQ-023 count = ram_cnt + in-flight + buffer occupancy, registered.
REQ-024 empty = (count == 0); full = (ram_cnt == N_ENTRIES).
REQ-025 Pointer wrap from N_ENTRIES-1 to 0 is seamless; order is strictly FIFO.
REQ-026 No overflow or underflow is possible by construction; the bench asserts that ram_cnt stays within 0..N_ENTRIES.

Reset
REQ-027 On rst_n low, all of the following clear asynchronously: wptr, rptr, ram_cnt, in-flight pipe, buffer, count.
REQ-028 Reset output values: in_rdy=0 while rst_n=0, then equal to not mem_yield; out_vld=0; mem_cs, mem_we, mem_re=0; count=0; empty=1; full=0.
REQ-029 Reset mid-operation discards in-flight reads; no stale mem_dout enters the buffer after reset release.
REQ-030 RAM contents are not cleared; they are not observable through the block until rewritten.

Configuration
REQ-031 Macro NX_FIFO_HW_CTRL_HWM_EN defined adds output hwm (same width as count) holding the maximum count since reset.
REQ-032 With NX_FIFO_HW_CTRL_HWM_EN defined, hwm updates when count > hwm and resets to 0.
REQ-033 With NX_FIFO_HW_CTRL_HWM_EN undefined, there is no hwm port and no hwm logic.

Verification
REQ-034 Single word: push 0xA5A5_0001 at cycle 0 with out_rdy=1 -> out_vld=1 at cycle 4 (RD_LATENCY=2) with out_dat=0xA5A5_0001; empty returns to 1.
REQ-035 Fill: out_rdy=0, push continuously -> 19 pushes accepted (16 RAM + 3 buffer), full=1, in_rdy=0, count=19; drain gives words in order.
REQ-036 Wrap: 40 pushes of an incrementing value with random out_rdy -> output is exactly 0..39 in order; pointers wrap twice.
REQ-037 Yield: hold mem_yield=1 for 3 cycles during streaming -> mem_cs=0 and in_rdy=0 for those cycles; no data is lost or duplicated.
REQ-038 Reset: assert rst_n=0 with 2 reads in flight -> count=0, out_vld=0 immediately; after release a new push returns only new data.
REQ-039 HWM: with NX_FIFO_HW_CTRL_HWM_EN defined, push 7 and pop all -> hwm=7 while count=0.

Source files
------------

// File: rtl/nx_fifo_1r1w_hw_ctrl.sv
// nx_fifo_1r1w_hw_ctrl: FIFO controller in front of a single-port-style 1R1W RAM
// with a fixed read latency. Writes go straight to RAM; reads are prefetched into
// a small register buffer sized to cover the RAM read latency, so the consumer
// sees a plain valid/ready stream.
// Optional feature: define NX_FIFO_HW_CTRL_HWM_EN to add the hwm output
// (highest count observed since reset).
module nx_fifo_1r1w_hw_ctrl #(
    parameter int N_DATA_BITS = 32,
    parameter int N_ENTRIES   = 16,
    parameter int RD_LATENCY  = 2
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_vld,
    input  logic [N_DATA_BITS-1:0]                     in_dat,
    output logic                                       in_rdy,
    output logic                                       out_vld,
    output logic [N_DATA_BITS-1:0]                     out_dat,
    input  logic                                       out_rdy,
    output logic                                       mem_cs,
    output logic                                       mem_we,
    output logic                                       mem_re,
    output logic [$clog2(N_ENTRIES)-1:0]               mem_waddr,
    output logic [$clog2(N_ENTRIES)-1:0]               mem_raddr,
    output logic [N_DATA_BITS-1:0]                     mem_din,
    input  logic [N_DATA_BITS-1:0]                     mem_dout,
    input  logic                                       mem_yield,
    output logic [$clog2(N_ENTRIES+RD_LATENCY+1):0]    count,
    output logic                                       empty,
    output logic                                       full
`ifdef NX_FIFO_HW_CTRL_HWM_EN
    ,
    output logic [$clog2(N_ENTRIES+RD_LATENCY+1):0]    hwm
`endif
);

    localparam int AW  = $clog2(N_ENTRIES);
    localparam int RW  = AW + 1;
    localparam int CW  = $clog2(N_ENTRIES + RD_LATENCY + 1) + 1;
    localparam int BD  = RD_LATENCY + 1;
    localparam int BPW = $clog2(BD);
    localparam int BCW = $clog2(BD + 1);
    localparam int FW  = $clog2(RD_LATENCY + 1);

    localparam logic [RW-1:0]  RAM_FULL = RW'(N_ENTRIES);
    localparam logic [BPW-1:0] BUF_LAST = BPW'(BD - 1);
    localparam logic [CW-1:0]  BUF_CAP  = CW'(BD);

    logic [AW-1:0]          wptr;
    logic [AW-1:0]          rptr;
    logic [RW-1:0]          ram_cnt;
    logic [RW-1:0]          ram_cnt_nxt;
    logic [RD_LATENCY-1:0]  pipe;
    logic [FW-1:0]          fly_cnt;
    logic [FW-1:0]          fly_cnt_nxt;
    logic [N_DATA_BITS-1:0] buf_mem [BD];
    logic [BPW-1:0]         buf_head;
    logic [BPW-1:0]         buf_tail;
    logic [BCW-1:0]         buf_cnt;
    logic [BCW-1:0]         buf_cnt_nxt;
    logic [CW-1:0]          credit;
    logic [CW-1:0]          count_nxt;
    logic                   push;
    logic                   rd;
    logic                   fill;
    logic                   pop;

    // Handshakes, read-issue decision and next-state occupancy counters
    always_comb begin
        in_rdy      = rst_n && (ram_cnt < RAM_FULL) && !mem_yield;
        push        = in_vld && in_rdy;
        credit      = CW'(buf_cnt) + CW'(fly_cnt);
        // ram_cnt only reflects committed writes, so a read can never hit the
        // entry being written this cycle.
        rd          = (ram_cnt != '0) && (credit < BUF_CAP) && !mem_yield;
        fill        = pipe[RD_LATENCY-1];
        out_vld     = (buf_cnt != '0);
        pop         = out_vld && out_rdy;
        out_dat     = buf_mem[buf_head];
        mem_cs      = push || rd;
        mem_we      = push;
        mem_re      = rd;
        mem_waddr   = wptr;
        mem_raddr   = rptr;
        mem_din     = in_dat;
        ram_cnt_nxt = ram_cnt + RW'(push) - RW'(rd);
        fly_cnt_nxt = fly_cnt + FW'(rd) - FW'(fill);
        buf_cnt_nxt = buf_cnt + BCW'(fill) - BCW'(pop);
        count_nxt   = CW'(ram_cnt_nxt) + CW'(fly_cnt_nxt) + CW'(buf_cnt_nxt);
        empty       = (count == '0);
        full        = (ram_cnt == RAM_FULL);
    end

    // RAM pointers and RAM occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (rd)   rptr <= rptr + 1'b1;
            ram_cnt <= ram_cnt_nxt;
        end
    end

    // Read-in-flight tracking; clearing it on reset drops any stale RAM data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe    <= '0;
            fly_cnt <= '0;
        end else begin
            pipe[0] <= rd;
            for (int unsigned i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            fly_cnt <= fly_cnt_nxt;
        end
    end

    // Output buffer: circular register FIFO filled from the RAM read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BD; i++) buf_mem[i] <= '0;
            buf_head <= '0;
            buf_tail <= '0;
            buf_cnt  <= '0;
        end else begin
            if (fill) begin
                buf_mem[buf_tail] <= mem_dout;
                buf_tail <= (buf_tail == BUF_LAST) ? '0 : buf_tail + 1'b1;
            end
            if (pop) buf_head <= (buf_head == BUF_LAST) ? '0 : buf_head + 1'b1;
            buf_cnt <= buf_cnt_nxt;
        end
    end

    // Total words held, registered from the next-state occupancies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else        count <= count_nxt;
    end

`ifdef NX_FIFO_HW_CTRL_HWM_EN
    // High-water mark of count since reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           hwm <= '0;
        else if (count > hwm) hwm <= count;
    end
`endif

endmodule

// File: tb/tb_nx_fifo_1r1w_hw_ctrl.sv
// Testbench for nx_fifo_1r1w_hw_ctrl with default parameters (32 bits, 16
// entries, read latency 2) and a behavioural RAM with the same read latency.
module tb_nx_fifo_1r1w_hw_ctrl;

    localparam int DW  = 32;
    localparam int NE  = 16;
    localparam int RDL = 2;
    localparam int AW  = $clog2(NE);
    localparam int CW  = $clog2(NE + RDL + 1) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_vld;
    logic [DW-1:0] in_dat;
    logic          in_rdy;
    logic          out_vld;
    logic [DW-1:0] out_dat;
    logic          out_rdy;
    logic          mem_cs, mem_we, mem_re;
    logic [AW-1:0] mem_waddr, mem_raddr;
    logic [DW-1:0] mem_din, mem_dout;
    logic          mem_yield;
    logic [CW-1:0] count;
    logic          empty, full;
`ifdef NX_FIFO_HW_CTRL_HWM_EN
    logic [CW-1:0] hwm;
`endif

    always #5 clk = ~clk;

    nx_fifo_1r1w_hw_ctrl #(.N_DATA_BITS(DW), .N_ENTRIES(NE), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_vld(in_vld), .in_dat(in_dat), .in_rdy(in_rdy),
        .out_vld(out_vld), .out_dat(out_dat), .out_rdy(out_rdy),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_re(mem_re),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_yield(mem_yield),
        .count(count), .empty(empty), .full(full)
`ifdef NX_FIFO_HW_CTRL_HWM_EN
        , .hwm(hwm)
`endif
    );

    // Behavioural RAM: data appears RDL cycles after the read-enable cycle
    logic [DW-1:0] ram [NE];
    logic [DW-1:0] rdp [RDL];
    always @(posedge clk) begin
        if (mem_cs && mem_we) ram[mem_waddr] <= mem_din;
        rdp[0] <= (mem_cs && mem_re) ? ram[mem_raddr] : 32'hDEAD_BEEF;
        for (int i = 1; i < RDL; i++) rdp[i] <= rdp[i-1];
    end
    assign mem_dout = rdp[RDL-1];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: scoreboard of accepted-but-not-popped words, RAM occupancy and
    // write/read word indices (addresses are index mod NE).
    logic [DW-1:0] sbq[$];
    int            m_ram = 0;
    int            m_wr  = 0;
    int            m_rd  = 0;
    logic          push_f, pop_f;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_in_rdy", in_rdy, 0);
            chk("rst_out_vld", out_vld, 0);
            chk("rst_mem_cs", mem_cs, 0);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            sbq.delete();
            m_ram = 0; m_wr = 0; m_rd = 0;
        end else begin
            push_f = in_vld && in_rdy;
            pop_f  = out_vld && out_rdy;
            chk("count", count, 64'(sbq.size()));
            chk("empty", empty, sbq.size() == 0);
            chk("full", full, m_ram == NE);
            chk("in_rdy", in_rdy, !mem_yield && (m_ram < NE));
            chk("mem_we", mem_we, push_f);
            chk("mem_cs", mem_cs, push_f || mem_re);
            if (push_f) begin
                chk("mem_waddr", mem_waddr, 64'(m_wr % NE));
                chk("mem_din", mem_din, in_dat);
            end
            if (mem_re) begin
                chk("rd_legal", (m_ram > 0) && !mem_yield, 1);
                chk("mem_raddr", mem_raddr, 64'(m_rd % NE));
            end
            if (out_vld) begin
                chk("out_vld_nonempty", sbq.size() != 0, 1);
                if (sbq.size() != 0) chk("out_dat", out_dat, sbq[0]);
            end
            if (pop_f && sbq.size() != 0) void'(sbq.pop_front());
            if (push_f) sbq.push_back(in_dat);
            m_ram = m_ram + int'(push_f) - int'(mem_re);
            m_wr  = m_wr + int'(push_f);
            m_rd  = m_rd + int'(mem_re);
            chk("ram_cnt_range", (m_ram >= 0) && (m_ram <= NE), 1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n, input int budget, input string name);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            step();
            in_vld  = 1'b0;
            out_rdy = 1'b1;
            @(negedge clk);
            if (out_vld) got++;
        end
        chk(name, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, sent, rcv, seen;
        rst_n = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b0; mem_yield = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_full", full, 0);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_in_rdy", in_rdy, 1);

        // Single word: pushed in cycle 0, visible in cycle 4
        step();
        in_vld = 1'b1; in_dat = 32'hA5A5_0001; out_rdy = 1'b1;
        @(negedge clk);
        chk("t0_accept", in_rdy, 1);
        chk("t0_out_vld", out_vld, 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            in_vld = 1'b0;
            @(negedge clk);
            chk("lat_out_vld", out_vld, k == 4);
            if (k == 4) chk("lat_out_dat", out_dat, 32'hA5A5_0001);
        end
        step();
        @(negedge clk);
        chk("single_empty", empty, 1);

        // Fill with no consumer: 16 in RAM plus 3 in the output buffer
        acc = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            out_rdy = 1'b0; in_vld = 1'b1; in_dat = 32'h1000_0000 + 32'(acc);
            @(negedge clk);
            if (in_rdy) acc++;
        end
        step();
        in_vld = 1'b0;
        @(negedge clk);
        chk("fill_accepted", acc, 19);
        chk("fill_full", full, 1);
        chk("fill_in_rdy", in_rdy, 0);
        chk("fill_count", count, 19);
        drain(19, 100, "fill_drain");

        // Wrap: 40 incrementing words against a random consumer
        sent = 0; rcv = 0;
        for (int c = 0; c < 400 && rcv < 40; c++) begin
            step();
            in_vld = (sent < 40); in_dat = 32'(sent); out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_vld && in_rdy) sent++;
            if (out_vld && out_rdy) begin
                chk("wrap_order", out_dat, 64'(rcv));
                rcv++;
            end
        end
        step();
        in_vld = 1'b0;
        chk("wrap_rcv", rcv, 40);

        // Yield for 3 cycles in the middle of a stream
        sent = 0; rcv = 0;
        for (int c = 0; c < 200 && rcv < 20; c++) begin
            step();
            mem_yield = (c >= 5 && c < 8);
            in_vld = (sent < 20); in_dat = 32'h2000_0000 + 32'(sent); out_rdy = 1'b1;
            @(negedge clk);
            if (mem_yield) begin
                chk("yield_cs", mem_cs, 0);
                chk("yield_in_rdy", in_rdy, 0);
            end
            if (in_vld && in_rdy) sent++;
            if (out_vld) begin
                chk("yield_order", out_dat, 32'h2000_0000 + 32'(rcv));
                rcv++;
            end
        end
        step();
        mem_yield = 1'b0; in_vld = 1'b0;
        chk("yield_rcv", rcv, 20);
        repeat (3) step();

        // Reset with two reads in flight
        in_vld = 1'b1; in_dat = 32'hBAD0_0001; out_rdy = 1'b0;
        step();
        in_dat = 32'hBAD0_0002;
        step();
        in_vld = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_async_count", count, 0);
        chk("rst_async_out_vld", out_vld, 0);
        repeat (2) step();
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            out_rdy = 1'b1;
            @(negedge clk);
            chk("post_rst_no_stale", out_vld, 0);
        end
        step();
        in_vld = 1'b1; in_dat = 32'h0000_1234;
        step();
        in_vld = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (out_vld) begin
                chk("post_rst_new_data", out_dat, 32'h0000_1234);
                seen = 1;
            end
            step();
        end
        chk("post_rst_seen", seen, 1);

        // Push 7 with no consumer, then drain everything
        step();
        out_rdy = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_vld = 1'b1; in_dat = 32'h3000_0000 + 32'(c);
            step();
        end
        in_vld = 1'b0;
        @(negedge clk);
        chk("hwm_phase_count", count, 7);
        drain(7, 60, "hwm_drain");
        repeat (2) step();
        @(negedge clk);
        chk("final_count", count, 0);
        chk("final_empty", empty, 1);
`ifdef NX_FIFO_HW_CTRL_HWM_EN
        chk("hwm", hwm, 7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
